// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared constants, FSM encoding and helpers for the DE-stage register hazard scoreboard.
package reg_hazard_scoreboard_pkg;

   localparam int NREGS         = 32;
   localparam int REGNOBITS     = 5;
   localparam int REGWORDS      = NREGS;
   localparam int SB_CNTBITS    = 2;
   localparam int FLUSH_CYCLES  = 2;
   localparam int FLUSH_CNTBITS = $clog2(FLUSH_CYCLES + 1);
   localparam int STATBITS      = 32;

   typedef enum logic {
      SB_RUN   = 1'b0,
      SB_FLUSH = 1'b1
   } sb_state_e;

   function automatic logic [STATBITS-1:0] sat_inc(input logic [STATBITS-1:0] v);
      return (v == {STATBITS{1'b1}}) ? v : v + STATBITS'(1);
   endfunction

endpackage

// File: rtl/sb_pending_counter.sv
// Per-register in-flight write counter: saturating up/down with a sticky underflow flag.
module sb_pending_counter
   import reg_hazard_scoreboard_pkg::*;
#(
   parameter int CNTBITS = SB_CNTBITS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               dec,
   output logic [CNTBITS-1:0] cnt,
   output logic               underflow
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         underflow <= 1'b0;
      end else begin
         // A retire with nothing pending is a protocol error; the count stays at 0.
         if (dec && cnt == '0)
            underflow <= 1'b1;
         if (inc && !dec && cnt != '1)
            cnt <= cnt + CNTBITS'(1);
         else if (dec && !inc && cnt != '0)
            cnt <= cnt - CNTBITS'(1);
      end
   end

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// DE-stage hazard scoreboard: RAW/WAW stall, mispredict flush FSM, pending-write tracking.
// Optional cycle statistics are built when SCOREBOARD_STATS_EN is defined.
module reg_hazard_scoreboard
   import reg_hazard_scoreboard_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid,
   input  logic                 issue_use_rs1,
   input  logic                 issue_use_rs2,
   input  logic [REGNOBITS-1:0] issue_rs1,
   input  logic [REGNOBITS-1:0] issue_rs2,
   input  logic                 issue_wr,
   input  logic [REGNOBITS-1:0] issue_rd,
   input  logic                 wb_wr,
   input  logic [REGNOBITS-1:0] wb_rd,
   input  logic                 br_mispred,
   output logic                 stall_DE,
   output logic                 squash_DE,
   output logic                 issue_fire,
   output logic                 busy,
   output logic                 err_underflow,
   output logic [STATBITS-1:0]  stat_hazard_cyc,
   output logic [STATBITS-1:0]  stat_flush_cyc,
   output sb_state_e            dbg_state
);

   localparam logic [SB_CNTBITS-1:0]    CMAX       = '1;
   localparam logic [SB_CNTBITS-1:0]    CNT_ONE    = SB_CNTBITS'(1);
   localparam logic [FLUSH_CNTBITS-1:0] FLUSH_LOAD = FLUSH_CNTBITS'(FLUSH_CYCLES);
   localparam logic [FLUSH_CNTBITS-1:0] FLUSH_ONE  = FLUSH_CNTBITS'(1);

   logic [SB_CNTBITS-1:0]    cnt [NREGS];
   logic [NREGS-1:0]         uf;
   sb_state_e                state, state_nx;
   logic [FLUSH_CNTBITS-1:0] fcnt, fcnt_nx;
   logic                     wr_ok, raw1, raw2, waw, hazard;

   // x0 is hardwired, so it never has a counter.
   assign cnt[0] = '0;
   assign uf[0]  = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      sb_pending_counter #(.CNTBITS(SB_CNTBITS)) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .inc       (issue_fire && wr_ok && issue_rd == REGNOBITS'(r)),
         .dec       (wb_wr && wb_rd == REGNOBITS'(r)),
         .cnt       (cnt[r]),
         .underflow (uf[r])
      );
   end

   // A last-outstanding write retiring this cycle is already readable (regfile writes on negedge).
   always_comb begin
      wr_ok  = issue_wr && issue_rd != '0;
      raw1   = issue_use_rs1 && issue_rs1 != '0 && cnt[issue_rs1] != '0 &&
               !(cnt[issue_rs1] == CNT_ONE && wb_wr && wb_rd == issue_rs1);
      raw2   = issue_use_rs2 && issue_rs2 != '0 && cnt[issue_rs2] != '0 &&
               !(cnt[issue_rs2] == CNT_ONE && wb_wr && wb_rd == issue_rs2);
      waw    = wr_ok && cnt[issue_rd] == CMAX && !(wb_wr && wb_rd == issue_rd);
      hazard = raw1 || raw2 || waw;
   end

   assign stall_DE      = (state != SB_RUN) || br_mispred || (issue_valid && hazard);
   assign issue_fire    = issue_valid && !stall_DE;
   assign squash_DE     = br_mispred || (state == SB_FLUSH);
   assign err_underflow = |uf;
   assign dbg_state     = state;

   always_comb begin
      busy = 1'b0;
      for (int r = 1; r < NREGS; r++)
         if (cnt[r] != '0)
            busy = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SB_RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nx;
         fcnt  <= fcnt_nx;
      end
   end

   // fcnt holds the FLUSH cycles still to spend, including the current one.
   always_comb begin
      state_nx = state;
      fcnt_nx  = fcnt;
      case (state)
         SB_RUN: begin
            if (br_mispred) begin
               state_nx = SB_FLUSH;
               fcnt_nx  = FLUSH_LOAD;
            end
         end
         SB_FLUSH: begin
            if (br_mispred) begin
               fcnt_nx = FLUSH_LOAD;
            end else if (fcnt <= FLUSH_ONE) begin
               state_nx = SB_RUN;
               fcnt_nx  = '0;
            end else begin
               fcnt_nx = fcnt - FLUSH_ONE;
            end
         end
         default: begin
            state_nx = SB_RUN;
            fcnt_nx  = '0;
         end
      endcase
   end

`ifdef SCOREBOARD_STATS_EN
   logic [STATBITS-1:0] hz_q, fl_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hz_q <= '0;
         fl_q <= '0;
      end else begin
         if (state == SB_RUN && issue_valid && hazard)
            hz_q <= sat_inc(hz_q);
         if (state == SB_FLUSH)
            fl_q <= sat_inc(fl_q);
      end
   end

   assign stat_hazard_cyc = hz_q;
   assign stat_flush_cyc  = fl_q;
`else
   assign stat_hazard_cyc = '0;
   assign stat_flush_cyc  = '0;
`endif

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench for reg_hazard_scoreboard; stat expectations follow SCOREBOARD_STATS_EN.
module tb_reg_hazard_scoreboard;
   import reg_hazard_scoreboard_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 issue_valid, issue_use_rs1, issue_use_rs2, issue_wr;
   logic [REGNOBITS-1:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
   logic                 wb_wr, br_mispred;
   logic                 stall_DE, squash_DE, issue_fire, busy, err_underflow;
   logic [31:0]          stat_hazard_cyc, stat_flush_cyc;
   sb_state_e            dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int n_stall;
   logic [31:0] exp_h, exp_f;

   reg_hazard_scoreboard dut (
      .clk             (clk),
      .reset           (reset),
      .issue_valid     (issue_valid),
      .issue_use_rs1   (issue_use_rs1),
      .issue_use_rs2   (issue_use_rs2),
      .issue_rs1       (issue_rs1),
      .issue_rs2       (issue_rs2),
      .issue_wr        (issue_wr),
      .issue_rd        (issue_rd),
      .wb_wr           (wb_wr),
      .wb_rd           (wb_rd),
      .br_mispred      (br_mispred),
      .stall_DE        (stall_DE),
      .squash_DE       (squash_DE),
      .issue_fire      (issue_fire),
      .busy            (busy),
      .err_underflow   (err_underflow),
      .stat_hazard_cyc (stat_hazard_cyc),
      .stat_flush_cyc  (stat_flush_cyc),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // checker
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change just after posedge, outputs are sampled at negedge
   task automatic drive(input logic v, input logic u1, input logic u2,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic wr, input logic [4:0] rd,
                        input logic wbw, input logic [4:0] wbrd, input logic mp);
      issue_valid   = v;
      issue_use_rs1 = u1;
      issue_use_rs2 = u2;
      issue_rs1     = rs1;
      issue_rs2     = rs2;
      issue_wr      = wr;
      issue_rd      = rd;
      wb_wr         = wbw;
      wb_rd         = wbrd;
      br_mispred    = mp;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      settle();
      check("rst_stall", stall_DE, 0);
      check("rst_squash", squash_DE, 0);
      check("rst_fire", issue_fire, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_underflow, 0);
      check("rst_state", 32'(dbg_state), 32'(SB_RUN));
      tick();

      // write x5, then a reader of x5 stalls until WB x5
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); settle();
      check("x5_wr_fire", issue_fire, 1);
      tick();
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); settle();
      check("x5_raw_stall", stall_DE, 1);
      check("x5_raw_nofire", issue_fire, 0);
      check("x5_busy", busy, 1);
      tick(); settle();
      check("x5_raw_stall2", stall_DE, 1);
      tick();
      drive(1, 1, 0, 5, 0, 0, 0, 1, 5, 0); settle();
      check("x5_wb_stall", stall_DE, 0);
      check("x5_wb_fire", issue_fire, 1);
      tick();
      idle(); settle();
      check("x5_drained", busy, 0);
      tick();

      // x0 is never tracked
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0); settle();
      check("x0_wr_fire", issue_fire, 1);
      tick();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); settle();
      check("x0_rd_stall", stall_DE, 0);
      check("x0_busy", busy, 0);
      tick();

      // x7 fills to CMAX=3; a 4th write stalls unless x7 retires in the same cycle
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); settle();
         check("x7_fill_fire", issue_fire, 1);
         tick();
      end
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); settle();
      check("x7_waw_stall", stall_DE, 1);
      tick();
      drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0); settle();
      check("x7_waw_wb_fire", issue_fire, 1);
      tick();
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); settle();
      check("x7_still_full", stall_DE, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
         tick();
      end
      idle(); settle();
      check("x7_drained", busy, 0);
      check("x7_no_err", err_underflow, 0);
      tick();

      // x9: simultaneous issue and retire keeps the count, retire at 0 flags underflow
      drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 0); settle();
      check("x9_both_fire", issue_fire, 1);
      tick();
      drive(1, 1, 0, 9, 0, 0, 0, 0, 0, 0); settle();
      check("x9_cnt_kept", stall_DE, 1);
      check("x9_no_err", err_underflow, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      tick();
      idle(); settle();
      check("x9_drained", busy, 0);
      check("x9_err_clean", err_underflow, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      tick();
      idle(); settle();
      check("x9_underflow", err_underflow, 1);
      check("x9_uf_busy", busy, 0);
      repeat (3) tick();
      settle();
      check("x9_uf_sticky", err_underflow, 1);
      tick();

      // single mispredict: stall and squash for 1+FLUSH_CYCLES cycles
      n_stall = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, (k == 0)); settle();
         if (!stall_DE) break;
         check("flush1_squash", squash_DE, 1);
         n_stall++;
         tick();
      end
      check("flush1_len", n_stall, 3);
      check("flush1_fire_after", issue_fire, 1);
      tick();

      // second pulse on the last FLUSH cycle extends by FLUSH_CYCLES
      n_stall = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, (k == 0 || k == 2)); settle();
         if (!stall_DE) break;
         n_stall++;
         tick();
      end
      check("flush2_len", n_stall, 5);
      check("flush2_squash_off", squash_DE, 0);
      tick();

      // stats: 4 RAW stall cycles plus one mispredict
      do_reset();
      check("st_rst_err", err_underflow, 0);
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, 0, 3, 0, 0, 0, 0, 0);
         tick();
      end
      drive(1, 0, 1, 0, 3, 0, 0, 1, 3, 0); settle();
      check("st_raw_release", issue_fire, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      idle();
      repeat (3) tick();
      settle();
`ifdef SCOREBOARD_STATS_EN
      exp_h = 32'd4;
      exp_f = 32'd2;
`else
      exp_h = 32'd0;
      exp_f = 32'd0;
`endif
      check("st_hazard", stat_hazard_cyc, exp_h);
      check("st_flush", stat_flush_cyc, exp_f);
      tick();

      // reset in the middle of FLUSH with a write still pending
      drive(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      idle(); settle();
      check("mid_state_flush", 32'(dbg_state), 32'(SB_FLUSH));
      check("mid_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check("mid_rst_state", 32'(dbg_state), 32'(SB_RUN));
      check("mid_rst_stall", stall_DE, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_hazard", stat_hazard_cyc, 0);
      check("mid_rst_flush", stat_flush_cyc, 0);

      // report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
